// File: rtl/imem_responder.sv
// imem_responder: direct-mapped instruction word buffer; a miss stalls fetch and refills over a variable-latency read bus.
// Define IMEM_RESPONDER_STATS_EN to add hit_cnt_o / miss_cnt_o counters.
module imem_responder #(
    parameter int LINES = 4,
    parameter int AW    = 30
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          stall_i,
    input  logic          inval_i,
    output logic [31:0]   rdata_o,
    output logic          stall_o,
    output logic          bus_cyc_o,
    output logic [AW-1:0] bus_addr_o,
    input  logic [31:0]   bus_data_i,
    input  logic          bus_ack_i
`ifdef IMEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]   hit_cnt_o,
    output logic [31:0]   miss_cnt_o
`endif
);
    localparam int IW = $clog2(LINES);
    localparam int TW = AW - IW;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cap_addr;
    logic            cap_vld;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]   tag_q  [LINES];
    logic [31:0]     data_q [LINES];
    logic [IW-1:0]   idx;
    logic [TW-1:0]   ctag;
    logic            hit, fill;

    assign idx        = cap_addr[IW-1:0];
    assign ctag       = cap_addr[AW-1:IW];
    assign hit        = cap_vld && valid_q[idx] && tag_q[idx] == ctag;
    assign fill       = state_q == WAIT && bus_ack_i;
    assign stall_o    = cap_vld && !hit;
    assign rdata_o    = hit ? data_q[idx] : '0;
    assign bus_cyc_o  = state_q != IDLE;
    assign bus_addr_o = bus_cyc_o ? cap_addr : '0;

    always_comb begin
        state_d = state_q;
        state_d = state_q == IDLE ? (stall_o ? REQ : IDLE) :
                  state_q == REQ  ? WAIT :
                  (bus_ack_i ? IDLE : WAIT);
    end

    // The in-flight fill is applied after the invalidate so it survives for its own entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cap_vld  <= 1'b0;
            cap_addr <= '0;
            valid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (!stall_i) begin
                cap_vld <= re_i;
                if (re_i) cap_addr <= raddr_i;
            end
            if (inval_i) valid_q <= '0;
            if (fill) valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q[idx]  <= ctag;
            data_q[idx] <= bus_data_i;
        end
    end

`ifdef IMEM_RESPONDER_STATS_EN
    logic fill_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_done  <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            fill_done <= fill;
            if (state_q == IDLE && hit && !fill_done) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (state_q == IDLE && stall_o) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule
